// File: rtl/alu_result_fifo.sv
// Result/flag capture FIFO behind the 4-bit ALU core: edge-triggered push/pop strobes, sticky overflow.
// Optional macro RESBUF_DROP_OLDEST_EN: a push into a full FIFO overwrites the oldest entry instead of being dropped.
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [7:0]                 res_in,
    input  logic                       carry_in,
    input  logic                       zero_in,
    input  logic                       push_req,
    input  logic                       pop_req,
    input  logic                       ovf_clr,
    output logic [7:0]                 rd_data,
    output logic                       rd_carry,
    output logic                       rd_zero,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [9:0]    storage [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_prev;
    logic          pop_prev;

    logic          push_ev;
    logic          pop_ev;
    logic          do_write;
    logic          adv_rd;
    logic          cnt_inc;
    logic          cnt_dec;
    logic          set_ovf;
    logic [9:0]    head;

    assign push_ev = push_req & ~push_prev & ena;
    assign pop_ev  = pop_req & ~pop_prev & ena;

    assign empty = (count == CW'(0));
    assign full  = (count == CW'(DEPTH));

    // Strobe history is tracked even while disabled, so an edge seen during ena=0 is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_prev <= 1'b0;
            pop_prev  <= 1'b0;
        end else begin
            push_prev <= push_req;
            pop_prev  <= pop_req;
        end
    end

    always_comb begin
        do_write = 1'b0;
        adv_rd   = 1'b0;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        set_ovf  = 1'b0;
        if (push_ev && pop_ev) begin
            do_write = 1'b1;
            if (empty) begin
                cnt_inc = 1'b1;
            end else begin
                // When full, wr_ptr == rd_ptr: the write lands in the slot being popped.
                adv_rd = 1'b1;
            end
        end else if (push_ev) begin
            if (!full) begin
                do_write = 1'b1;
                cnt_inc  = 1'b1;
            end else begin
                set_ovf = 1'b1;
`ifdef RESBUF_DROP_OLDEST_EN
                do_write = 1'b1;
                adv_rd   = 1'b1;
`endif
            end
        end else if (pop_ev && !empty) begin
            adv_rd  = 1'b1;
            cnt_dec = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (adv_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (cnt_inc) begin
                count <= count + CW'(1);
            end else if (cnt_dec) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage carries no reset; empty gating hides stale contents.
    always_ff @(posedge clk) begin
        if (do_write) begin
            storage[wr_ptr] <= {carry_in, zero_in, res_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (set_ovf) begin
            ovf <= 1'b1;
        end else if (ovf_clr && ena) begin
            ovf <= 1'b0;
        end
    end

    assign head     = empty ? 10'd0 : storage[rd_ptr];
    assign rd_carry = head[9];
    assign rd_zero  = head[8];
    assign rd_data  = head[7:0];

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DEPTH=4); expectations follow RESBUF_DROP_OLDEST_EN when defined.
module tb_alu_result_fifo;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] res_in;
    logic       carry_in;
    logic       zero_in;
    logic       push_req;
    logic       pop_req;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       rd_carry;
    logic       rd_zero;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_fifo #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .res_in   (res_in),
        .carry_in (carry_in),
        .zero_in  (zero_in),
        .push_req (push_req),
        .pop_req  (pop_req),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .rd_carry (rd_carry),
        .rd_zero  (rd_zero),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] v, input logic c, input logic z);
        @(negedge clk);
        res_in   = v;
        carry_in = c;
        zero_in  = z;
        push_req = 1'b1;
        @(negedge clk);
        push_req = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        pop_req = 1'b1;
        @(negedge clk);
        pop_req = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] v);
        @(negedge clk);
        res_in   = v;
        carry_in = 1'b0;
        zero_in  = 1'b0;
        push_req = 1'b1;
        pop_req  = 1'b1;
        @(negedge clk);
        push_req = 1'b0;
        pop_req  = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_v;
        rst_n = 1'b0; ena = 1'b1; res_in = 8'h00; carry_in = 1'b0; zero_in = 1'b0;
        push_req = 1'b0; pop_req = 1'b0; ovf_clr = 1'b0;

        // Reset held while strobes toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push_req = ~push_req;
            pop_req  = ~pop_req;
            res_in   = 8'hA5;
        end
        @(negedge clk);
        push_req = 1'b0; pop_req = 1'b0;
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_data", rd_data, 8'h00);
        check("rst_ovf", ovf, 0);
        check("rst_full", full, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_empty", empty, 1);
        check("post_rst_count", count, 0);

        // Ordering with flags
        push(8'h05, 1'b0, 1'b0);
        check("ord_first_head", rd_data, 8'h05);
        check("ord_first_empty", empty, 0);
        push(8'h1E, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1);
        check("ord_count3", count, 3);
        check("ord_h0_carry", rd_carry, 0);
        check("ord_h0_zero", rd_zero, 0);
        pop();
        check("ord_h1_data", rd_data, 8'h1E);
        check("ord_h1_carry", rd_carry, 1);
        check("ord_h1_zero", rd_zero, 0);
        pop();
        check("ord_h2_data", rd_data, 8'h00);
        check("ord_h2_zero", rd_zero, 1);
        check("ord_h2_carry", rd_carry, 0);
        pop();
        check("ord_final_empty", empty, 1);
        check("ord_final_data", rd_data, 8'h00);
        check("ord_final_count", count, 0);

        // Held strobes give one event each
        @(negedge clk);
        res_in = 8'h42; carry_in = 1'b0; zero_in = 1'b0; push_req = 1'b1;
        repeat (10) @(negedge clk);
        push_req = 1'b0;
        @(negedge clk);
        check("held_push_count", count, 1);
        check("held_push_data", rd_data, 8'h42);
        pop_req = 1'b1;
        repeat (5) @(negedge clk);
        pop_req = 1'b0;
        @(negedge clk);
        check("held_pop_count", count, 0);
        check("held_pop_empty", empty, 1);

        // Overflow
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b0, 1'b0);
        check("ovf_full", full, 1);
        check("ovf_flag", ovf, 1);
        check("ovf_count", count, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef RESBUF_DROP_OLDEST_EN
            exp_v = 8'(i + 2);
`else
            exp_v = 8'(i + 1);
`endif
            check("ovf_pop_data", rd_data, exp_v);
            pop();
        end
        check("ovf_drained", empty, 1);
        check("ovf_still_set", ovf, 1);
        pulse_clr();
        check("ovf_cleared", ovf, 0);

        // Simultaneous push+pop on empty
        push_pop(8'h77);
        check("sim_empty_count", count, 1);
        check("sim_empty_head", rd_data, 8'h77);
        pop();
        check("sim_empty_drain", empty, 1);

        // Simultaneous push+pop on full
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b0, 1'b0);
        check("sim_full_pre", full, 1);
        push_pop(8'hB4);
        check("sim_full_count", count, 4);
        check("sim_full_head", rd_data, 8'hA1);
        check("sim_full_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) begin
            exp_v = (i == 3) ? 8'hB4 : 8'hA1 + 8'(i);
            check("sim_full_pop", rd_data, exp_v);
            pop();
        end
        check("sim_full_drain", empty, 1);

        // Edges while disabled are lost
        ena = 1'b0;
        push(8'h99, 1'b1, 1'b1);
        ena = 1'b1;
        @(negedge clk);
        check("ena_push_count", count, 0);
        check("ena_push_empty", empty, 1);

        // ovf_clr ignored while disabled
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1'b0, 1'b0);
        check("ena_ovf_set", ovf, 1);
        ena = 1'b0;
        pulse_clr();
        check("ena_clr_blocked", ovf, 1);
        ena = 1'b1;
        pulse_clr();
        check("ena_clr_ok", ovf, 0);
        repeat (4) pop();
        check("ena_drain", empty, 1);

        // Pointer wrap with paired push/pop
        for (int i = 0; i < 6; i++) begin
            push(8'hC0 + 8'(i), i[0], 1'b0);
            check("wrap_data", rd_data, 8'hC0 + 8'(i));
            check("wrap_carry", rd_carry, i[0]);
            pop();
            check("wrap_empty", empty, 1);
        end

        // Asynchronous reset mid-operation
        push(8'h33, 1'b0, 1'b0);
        push(8'h44, 1'b0, 1'b0);
        check("async_pre_count", count, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_empty", empty, 1);
        check("async_count", count, 0);
        check("async_data", rd_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("async_after_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
